ramio_arbiter: RTL and testbench

RAMIO_ARBITER -- requirements
Module: ramio_arbiter

---
 rtl/ramio_arbiter.sv | 156 +++++++++++++++
 tb/tb_ramio_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_arbiter.sv
// Two-requester round-robin arbiter for a single shared RAMIO port.
// Optional ownership timeout compiled in with RAMIO_ARBITER_TIMEOUT_EN.
module ramio_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_enable,
    input  logic [1:0]  m0_write_type,
    input  logic [2:0]  m0_read_type,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_in,
    output logic [31:0] m0_data_out,
    output logic        m0_data_out_ready,
    output logic        m0_busy,
    input  logic        m1_enable,
    input  logic [1:0]  m1_write_type,
    input  logic [2:0]  m1_read_type,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_in,
    output logic [31:0] m1_data_out,
    output logic        m1_data_out_ready,
    output logic        m1_busy,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic [31:0] ramio_data_out,
    input  logic        ramio_data_out_ready,
    input  logic        ramio_busy,
    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   nat_rel;
    logic   force_rel;
    logic   release_own;
    logic   own0, own1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef RAMIO_ARBITER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // Counter holds the number of cycles already owned; hit on the last permitted cycle.
    always_comb begin
        force_rel = (state_q != IDLE) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
        cnt_d     = (state_q == IDLE || release_own) ? '0 : cnt_q + 32'd1;
        timeout_d = force_rel && !nat_rel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q && !rst;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        nat_rel      = 1'b0;
        release_own  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_enable && m1_enable) state_d = last_owner_q ? OWN0 : OWN1;
                else if (m0_enable)         state_d = OWN0;
                else if (m1_enable)         state_d = OWN1;
            end
            OWN0: begin
                nat_rel     = !m0_enable && !ramio_busy;
                release_own = nat_rel || force_rel;
                if (release_own) begin
                    last_owner_d = 1'b0;
                    state_d      = m1_enable ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                nat_rel     = !m1_enable && !ramio_busy;
                release_own = nat_rel || force_rel;
                if (release_own) begin
                    last_owner_d = 1'b1;
                    state_d      = m0_enable ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Outputs are gated by rst so the port reads idle while reset is held.
    always_comb begin
        own0              = (state_q == OWN0) && !rst;
        own1              = (state_q == OWN1) && !rst;
        ramio_enable      = 1'b0;
        ramio_write_type  = '0;
        ramio_read_type   = '0;
        ramio_address     = '0;
        ramio_data_in     = '0;
        m0_data_out       = '0;
        m0_data_out_ready = 1'b0;
        m0_busy           = 1'b0;
        m1_data_out       = '0;
        m1_data_out_ready = 1'b0;
        m1_busy           = 1'b0;
        if (own0) begin
            ramio_enable      = m0_enable;
            ramio_write_type  = m0_write_type;
            ramio_read_type   = m0_read_type;
            ramio_address     = m0_address;
            ramio_data_in     = m0_data_in;
            m0_data_out       = ramio_data_out;
            m0_data_out_ready = ramio_data_out_ready;
            m0_busy           = ramio_busy;
            m1_busy           = 1'b1;
        end else if (own1) begin
            ramio_enable      = m1_enable;
            ramio_write_type  = m1_write_type;
            ramio_read_type   = m1_read_type;
            ramio_address     = m1_address;
            ramio_data_in     = m1_data_in;
            m1_data_out       = ramio_data_out;
            m1_data_out_ready = ramio_data_out_ready;
            m1_busy           = ramio_busy;
            m0_busy           = 1'b1;
        end
        grant = {own1, own0};
    end

endmodule

// File: tb/tb_ramio_arbiter.sv
// Self-checking bench for ramio_arbiter: directed scenarios plus randomized traffic
// against an ownership model; timeout expectations follow RAMIO_ARBITER_TIMEOUT_EN.
module tb_ramio_arbiter;

    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_enable, m1_enable;
    logic [1:0]  m0_write_type, m1_write_type;
    logic [2:0]  m0_read_type, m1_read_type;
    logic [31:0] m0_address, m1_address, m0_data_in, m1_data_in;
    logic [31:0] m0_data_out, m1_data_out;
    logic        m0_data_out_ready, m1_data_out_ready, m0_busy, m1_busy;
    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address, ramio_data_in, ramio_data_out;
    logic        ramio_data_out_ready, ramio_busy;
    logic [1:0]  grant;
    logic        timeout;

    always #5 clk = ~clk;

    ramio_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .m0_enable(m0_enable), .m0_write_type(m0_write_type), .m0_read_type(m0_read_type),
        .m0_address(m0_address), .m0_data_in(m0_data_in), .m0_data_out(m0_data_out),
        .m0_data_out_ready(m0_data_out_ready), .m0_busy(m0_busy),
        .m1_enable(m1_enable), .m1_write_type(m1_write_type), .m1_read_type(m1_read_type),
        .m1_address(m1_address), .m1_data_in(m1_data_in), .m1_data_out(m1_data_out),
        .m1_data_out_ready(m1_data_out_ready), .m1_busy(m1_busy),
        .ramio_enable(ramio_enable), .ramio_write_type(ramio_write_type),
        .ramio_read_type(ramio_read_type), .ramio_address(ramio_address),
        .ramio_data_in(ramio_data_in), .ramio_data_out(ramio_data_out),
        .ramio_data_out_ready(ramio_data_out_ready), .ramio_busy(ramio_busy),
        .grant(grant), .timeout(timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the port (-1 none), who held it last, cycles held.
    int owner  = -1;
    int last   = 1;
    int held   = 0;
    bit exp_to = 1'b0;

    always @(posedge clk) begin : model
        logic [1:0] en;
        bit done, forced;
        en     = {m1_enable, m0_enable};
        exp_to = 1'b0;
        if (rst) begin
            owner = -1;
            last  = 1;
            held  = 0;
        end else if (owner < 0) begin
            if (en == 2'b11)  owner = 1 - last;
            else if (en[0])   owner = 0;
            else if (en[1])   owner = 1;
            held = 0;
        end else begin
            held++;
            done   = !en[owner] && !ramio_busy;
            forced = 1'b0;
`ifdef RAMIO_ARBITER_TIMEOUT_EN
            forced = !done && (held == TC);
`endif
            if (done || forced) begin
                last   = owner;
                exp_to = forced;
                owner  = en[1 - owner] ? 1 - owner : -1;
                held   = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [69:0] exp_r;
        logic [33:0] exp_m0, exp_m1;
        logic [1:0]  exp_g;
        exp_r  = '0;
        exp_m0 = '0;
        exp_m1 = '0;
        exp_g  = 2'b00;
        if (!rst && owner == 0) begin
            exp_r  = {m0_enable, m0_write_type, m0_read_type, m0_address, m0_data_in};
            exp_m0 = {ramio_data_out, ramio_data_out_ready, ramio_busy};
            exp_m1 = {32'h0, 1'b0, 1'b1};
            exp_g  = 2'b01;
        end else if (!rst && owner == 1) begin
            exp_r  = {m1_enable, m1_write_type, m1_read_type, m1_address, m1_data_in};
            exp_m1 = {ramio_data_out, ramio_data_out_ready, ramio_busy};
            exp_m0 = {32'h0, 1'b0, 1'b1};
            exp_g  = 2'b10;
        end
        check("model_grant", grant, exp_g);
        check("model_ramio", {ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in}, exp_r);
        check("model_m0", {m0_data_out, m0_data_out_ready, m0_busy}, exp_m0);
        check("model_m1", {m1_data_out, m1_data_out_ready, m1_busy}, exp_m1);
        check("model_timeout", timeout, exp_to && !rst);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_enable = 0; m0_write_type = 0; m0_read_type = 0; m0_address = 0; m0_data_in = 0;
        m1_enable = 0; m1_write_type = 0; m1_read_type = 0; m1_address = 0; m1_data_in = 0;
        ramio_data_out = 0; ramio_data_out_ready = 0; ramio_busy = 0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0, n1, to_cnt;
        logic [1:0] g, g_at_to;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("reset_grant", grant, 2'b00);
        check("reset_ramio_en", ramio_enable, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // m0 word write, m1 idle
        m0_enable = 1; m0_write_type = 2'b11; m0_address = 32'h0000_0010; m0_data_in = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_lat_grant", grant, 2'b00);
        check("wr_lat_en", ramio_enable, 1'b0);
        tick();
        @(negedge clk);
        check("wr_grant", grant, 2'b01);
        check("wr_en", ramio_enable, 1'b1);
        check("wr_addr", ramio_address, 32'h0000_0010);
        check("wr_data", ramio_data_in, 32'hDEADBEEF);
        check("wr_type", ramio_write_type, 2'b11);
        m0_enable = 0; ramio_busy = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("wr_hold_grant", grant, 2'b01);
        check("wr_hold_en", ramio_enable, 1'b0);
        ramio_busy = 0;
        tick();
        @(negedge clk);
        check("wr_release_grant", grant, 2'b00);

        // Simultaneous reads after reset: m0 first, then m1 without a gap
        pulse_reset();
        m0_enable = 1; m0_read_type = 3'b110; m0_address = 32'h100;
        m1_enable = 1; m1_read_type = 3'b010; m1_address = 32'h200;
        ramio_data_out = 32'h1234_5678; ramio_data_out_ready = 1;
        tick();
        @(negedge clk);
        check("rd_first_grant", grant, 2'b01);
        check("rd_m0_ready", m0_data_out_ready, 1'b1);
        check("rd_m1_ready_blocked", m1_data_out_ready, 1'b0);
        m0_enable = 0;
        tick();
        @(negedge clk);
        check("rd_second_grant", grant, 2'b10);
        check("rd_m1_ready", m1_data_out_ready, 1'b1);
        check("rd_m1_data", m1_data_out, 32'h1234_5678);
        check("rd_m1_addr", ramio_address, 32'h200);

        // Round-robin over 8 back-to-back transactions
        pulse_reset();
        m0_enable = 1; m1_enable = 1;
        tick();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = grant;
            check("rr_grant", g, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (g == 2'b01) n0++;
            if (g == 2'b10) n1++;
            if (g == 2'b01) m0_enable = 0; else m1_enable = 0;
            tick();
            m0_enable = 1; m1_enable = 1;
        end
        check("rr_count_m0", n0, 4);
        check("rr_count_m1", n1, 4);

        // Reset during a busy OWN1 transaction
        pulse_reset();
        m1_enable = 1;
        tick();
        ramio_busy = 1;
        tick();
        rst = 1;
        @(negedge clk);
        check("rst_hold_grant", grant, 2'b00);
        check("rst_hold_busy", m0_busy, 1'b0);
        tick();
        rst = 0; ramio_busy = 0; m0_enable = 1; m1_enable = 1;
        @(negedge clk);
        check("post_rst_grant", grant, 2'b00);
        check("post_rst_en", ramio_enable, 1'b0);
        tick();
        @(negedge clk);
        check("post_rst_tie", grant, 2'b01);

        // m1 holds indefinitely while m0 waits
        pulse_reset();
        m1_enable = 1;
        tick();
        m0_enable = 1;
        to_cnt = 0;
        g_at_to = 2'b00;
        for (int i = 0; i < 3 * TC; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                to_cnt++;
                if (to_cnt == 1) g_at_to = grant;
            end
            if (to_cnt > 0) m0_enable = 0;
            tick();
        end
`ifdef RAMIO_ARBITER_TIMEOUT_EN
        check("to_pulse_count", to_cnt, 1);
        check("to_grant_switch", g_at_to, 2'b01);
`else
        check("to_pulse_count", to_cnt, 0);
        @(negedge clk);
        check("to_grant_held", grant, 2'b10);
`endif

        // Randomized traffic
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) m0_enable = ~m0_enable;
            if ($urandom_range(0, 3) == 0) m1_enable = ~m1_enable;
            m0_write_type = 2'($urandom); m0_read_type = 3'($urandom);
            m1_write_type = 2'($urandom); m1_read_type = 3'($urandom);
            m0_address = $urandom; m0_data_in = $urandom;
            m1_address = $urandom; m1_data_in = $urandom;
            ramio_data_out = $urandom;
            ramio_data_out_ready = 1'($urandom);
            ramio_busy = ($urandom_range(0, 3) == 0);
            tick();
        end

        rst = 0;
        idle_inputs();
        tick();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
